// File: rtl/rv523_bus_pkg.sv
// Shared types, frame constants and checksum helper for the RV523 nibble-serial bus.
// ST_CHK exists only when RV523_NIBBLE_CHK_EN is defined.
package rv523_bus_pkg;

   localparam int OP_WRITE     = 3;
   localparam int ADDR_NIBBLES = 2;
   localparam int DATA_NIBBLES = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3
`ifdef RV523_NIBBLE_CHK_EN
      ,
      ST_CHK   = 3'd4
`endif
   } state_e;

   function automatic logic [3:0] nibble_xor(input logic [31:0] word);
      logic [3:0] acc;
      acc = 4'h0;
      for (int i = 0; i < DATA_NIBBLES; i++) begin
         acc = acc ^ word[4*i +: 4];
      end
      return acc;
   endfunction

endpackage

// File: rtl/rv523_nibble_shifter.sv
// 32-bit nibble shift register: parallel load, or shift right by one nibble with a
// new nibble entering at the top. Shift-out is a shift with a zero nibble in.
module rv523_nibble_shifter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] load_data_i,
   input  logic        shift_i,
   input  logic [3:0]  nib_i,
   output logic [31:0] data_o,
   output logic [3:0]  nib_o
);

   logic [31:0] data_q;
   logic [31:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         data_d = {nib_i, data_q[31:4]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;
   assign nib_o  = data_q[3:0];

endmodule

// File: rtl/rv523_nibble_responder.sv
// RV523 nibble-serial bus responder: DEPTH x 32-bit word store behind a request-frame FSM.
// Optional frame/response checksum nibble enabled by defining RV523_NIBBLE_CHK_EN.
module rv523_nibble_responder
   import rv523_bus_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       I_VALID,
   input  logic [3:0] I_D,
   output logic       O_VALID,
   output logic [3:0] O_D,
   output logic       BUSY,
   output logic       ERR
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e      state_q;
   logic [3:0]  op_q;
   logic [7:0]  addr_q;
   logic [3:0]  cnt_q;
   logic        o_valid_q;
   logic [3:0]  o_d_q;
   logic        busy_q;
   logic        err_q;
`ifdef RV523_NIBBLE_CHK_EN
   logic [3:0]  acc_q;
   logic [3:0]  resp_chk_q;
   logic        resp_q;
`endif

   logic [31:0] mem_q [DEPTH];

   logic        sh_load;
   logic        sh_shift;
   logic [3:0]  sh_in;
   logic [31:0] sh_load_data;
   logic [31:0] sh_data;
   logic [3:0]  sh_nib;

   logic        mem_we;
   logic [AW-1:0] mem_widx;
   logic [31:0] mem_wdata;
   logic [7:0]  rd_addr;
   logic [AW-1:0] rd_idx;
   logic [31:0] rd_word;
   logic        start_read;
   logic        rsvd;
   logic        is_write;
   logic        unused_addr;

   assign rsvd     = |op_q[2:0];
   assign is_write = op_q[OP_WRITE];

   // Upper address bits beyond the word index are deliberately ignored.
   assign unused_addr = (^rd_addr) ^ (^addr_q);

   always_comb begin
      sh_shift   = 1'b0;
      sh_in      = I_D;
      mem_we     = 1'b0;
      mem_wdata  = sh_data;
      mem_widx   = addr_q[AW-1:0];
      start_read = 1'b0;
`ifdef RV523_NIBBLE_CHK_EN
      rd_addr    = addr_q;
`else
      rd_addr    = {addr_q[3:0], I_D};
`endif
      case (state_q)
         ST_ADDR: begin
`ifndef RV523_NIBBLE_CHK_EN
            if (I_VALID && cnt_q == 4'(ADDR_NIBBLES - 1) && !is_write && !rsvd) begin
               start_read = 1'b1;
            end
`endif
         end
         ST_WDATA: begin
            if (I_VALID) begin
               sh_shift = 1'b1;
`ifndef RV523_NIBBLE_CHK_EN
               // Commit on the edge that accepts DATA7, so fold it in directly.
               if (cnt_q == 4'(DATA_NIBBLES - 1) && !rsvd) begin
                  mem_we    = 1'b1;
                  mem_wdata = {I_D, sh_data[31:4]};
               end
`endif
            end
         end
         ST_RDATA: begin
            if (cnt_q != 4'(DATA_NIBBLES)) begin
               sh_shift = 1'b1;
               sh_in    = 4'h0;
            end
         end
`ifdef RV523_NIBBLE_CHK_EN
         ST_CHK: begin
            if (!resp_q && I_VALID && I_D == acc_q && !rsvd) begin
               if (is_write) begin
                  mem_we = 1'b1;
               end else begin
                  start_read = 1'b1;
               end
            end
         end
`endif
         default: begin
         end
      endcase
   end

   assign sh_load      = start_read;
   assign rd_idx       = rd_addr[AW-1:0];
   assign rd_word      = mem_q[rd_idx];
   // DATA0 goes straight to O_D; the shifter holds the remaining seven nibbles.
   assign sh_load_data = {4'h0, rd_word[31:4]};

   rv523_nibble_shifter u_shifter (
      .clk_i       (CLK),
      .rst_i       (RST),
      .load_i      (sh_load),
      .load_data_i (sh_load_data),
      .shift_i     (sh_shift),
      .nib_i       (sh_in),
      .data_o      (sh_data),
      .nib_o       (sh_nib)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         op_q       <= 4'h0;
         addr_q     <= 8'h00;
         cnt_q      <= 4'd0;
         o_valid_q  <= 1'b0;
         o_d_q      <= 4'h0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef RV523_NIBBLE_CHK_EN
         acc_q      <= 4'h0;
         resp_chk_q <= 4'h0;
         resp_q     <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (I_VALID) begin
                  op_q    <= I_D;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  state_q <= ST_ADDR;
`ifdef RV523_NIBBLE_CHK_EN
                  acc_q   <= I_D;
`endif
               end
            end

            ST_ADDR: begin
               if (!I_VALID) begin
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  addr_q <= {addr_q[3:0], I_D};
`ifdef RV523_NIBBLE_CHK_EN
                  acc_q  <= acc_q ^ I_D;
`endif
                  if (cnt_q != 4'(ADDR_NIBBLES - 1)) begin
                     cnt_q <= cnt_q + 4'd1;
                  end else begin
                     cnt_q <= 4'd0;
                     if (is_write) begin
                        state_q <= ST_WDATA;
`ifdef RV523_NIBBLE_CHK_EN
                     end else begin
                        resp_q  <= 1'b0;
                        state_q <= ST_CHK;
                     end
`else
                     end else if (start_read) begin
                        o_valid_q <= 1'b1;
                        o_d_q     <= rd_word[3:0];
                        cnt_q     <= 4'd1;
                        state_q   <= ST_RDATA;
                     end else begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                     end
`endif
                  end
               end
            end

            ST_WDATA: begin
               if (!I_VALID) begin
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
`ifdef RV523_NIBBLE_CHK_EN
                  acc_q <= acc_q ^ I_D;
`endif
                  if (cnt_q != 4'(DATA_NIBBLES - 1)) begin
                     cnt_q <= cnt_q + 4'd1;
                  end else begin
                     cnt_q <= 4'd0;
`ifdef RV523_NIBBLE_CHK_EN
                     resp_q  <= 1'b0;
                     state_q <= ST_CHK;
`else
                     busy_q  <= 1'b0;
                     err_q   <= rsvd;
                     state_q <= ST_IDLE;
`endif
                  end
               end
            end

            ST_RDATA: begin
               if (cnt_q != 4'(DATA_NIBBLES)) begin
                  o_d_q <= sh_nib;
                  cnt_q <= cnt_q + 4'd1;
               end else begin
`ifdef RV523_NIBBLE_CHK_EN
                  o_d_q   <= resp_chk_q;
                  resp_q  <= 1'b1;
                  state_q <= ST_CHK;
`else
                  o_valid_q <= 1'b0;
                  o_d_q     <= 4'h0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
`endif
               end
            end

`ifdef RV523_NIBBLE_CHK_EN
            // Shared by the trailing request checksum and the response checksum nibble.
            ST_CHK: begin
               if (resp_q) begin
                  o_valid_q <= 1'b0;
                  o_d_q     <= 4'h0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (!I_VALID) begin
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (start_read) begin
                  o_valid_q  <= 1'b1;
                  o_d_q      <= rd_word[3:0];
                  resp_chk_q <= nibble_xor(rd_word);
                  cnt_q      <= 4'd1;
                  state_q    <= ST_RDATA;
               end else begin
                  busy_q  <= 1'b0;
                  err_q   <= !mem_we;
                  state_q <= ST_IDLE;
               end
            end
`endif

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign O_VALID = o_valid_q;
   assign O_D     = o_d_q;
   assign BUSY    = busy_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_rv523_nibble_responder.sv
// Directed bench for rv523_nibble_responder (DEPTH=16); adapts to RV523_NIBBLE_CHK_EN.
`timescale 1ns/1ps
module tb_rv523_nibble_responder;

`ifdef RV523_NIBBLE_CHK_EN
   localparam int         NR      = 9;
   localparam logic [8:0] VLD_ALL = 9'h1FF;
`else
   localparam int         NR      = 8;
   localparam logic [8:0] VLD_ALL = 9'h0FF;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       i_valid;
   logic [3:0] i_d;
   logic       o_valid;
   logic [3:0] o_d;
   logic       busy;
   logic       err;

   int vec_cnt = 0;
   int err_cnt = 0;

   rv523_nibble_responder #(.DEPTH(16)) dut (
      .CLK     (clk),
      .RST     (rst),
      .I_VALID (i_valid),
      .I_D     (i_d),
      .O_VALID (o_valid),
      .O_D     (o_d),
      .BUSY    (busy),
      .ERR     (err)
   );

   always #5 clk = ~clk;

   task automatic step(input logic v, input logic [3:0] d);
      i_valid = v;
      i_d     = d;
      @(posedge clk);
      #1;
   endtask

   // Read frame, then collect the response nibbles one per cycle.
   task automatic do_read(input logic [7:0] addr, output logic [35:0] nibs,
                          output logic [8:0] vld, output logic pre_v,
                          output logic busy_after, output logic ov_after);
      nibs = '0;
      vld  = '0;
      step(1'b1, 4'h0);
      step(1'b1, addr[7:4]);
`ifdef RV523_NIBBLE_CHK_EN
      step(1'b1, addr[3:0]);
      pre_v = o_valid;
      step(1'b1, addr[7:4] ^ addr[3:0]);
`else
      pre_v = o_valid;
      step(1'b1, addr[3:0]);
`endif
      for (int i = 0; i < NR; i++) begin
         nibs[4*i +: 4] = o_d;
         vld[i]         = o_valid;
         step(1'b0, 4'h0);
      end
      busy_after = busy;
      ov_after   = o_valid;
      $display("read  addr=%h data=%h vld=%b", addr, nibs, vld);
   endtask

   // Write frame; drop_at<8 drops I_VALID in place of that data nibble.
   task automatic do_write(input logic [3:0] op, input logic [7:0] addr, input logic [31:0] data,
                           input int drop_at, input logic [3:0] chk_delta,
                           output logic busy_op, output logic err_end,
                           output logic busy_end, output logic ov_seen);
      logic [3:0] acc;
      logic       aborted;
      aborted = 1'b0;
      acc     = op ^ addr[7:4] ^ addr[3:0];
      step(1'b1, op);
      busy_op = busy;
      ov_seen = o_valid;
      step(1'b1, addr[7:4]);
      ov_seen |= o_valid;
      step(1'b1, addr[3:0]);
      ov_seen |= o_valid;
      for (int i = 0; i < 8; i++) begin
         if (!aborted) begin
            if (i == drop_at) begin
               step(1'b0, 4'h0);
               aborted = 1'b1;
            end else begin
               acc = acc ^ data[4*i +: 4];
               step(1'b1, data[4*i +: 4]);
               ov_seen |= o_valid;
            end
         end
      end
`ifdef RV523_NIBBLE_CHK_EN
      if (!aborted) begin
         step(1'b1, acc ^ chk_delta);
         ov_seen |= o_valid;
      end
`else
      if (chk_delta != 4'h0) begin
         acc = 4'h0;
      end
`endif
      err_end  = err;
      busy_end = busy;
      i_valid  = 1'b0;
      $display("write op=%h addr=%h data=%h drop=%0d err=%b", op, addr, data, drop_at, err_end);
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      i_valid = 1'b0;
      i_d     = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++; if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
      vec_cnt++; if (o_d !== 4'h0) begin err_cnt++; $display("FAIL reset_o_d got=%h want=0", o_d); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b want=0", busy); end
      vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL reset_err got=%b want=0", err); end
      rst = 1'b0;
      step(1'b0, 4'h0);
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_write_read();
      logic bo, ee, be, ov, pv, ba, oa;
      logic [35:0] nibs;
      logic [8:0]  vld;
      do_write(4'h8, 8'h03, 32'hDEADBEEF, 8, 4'h0, bo, ee, be, ov);
      vec_cnt++; if (bo !== 1'b1) begin err_cnt++; $display("FAIL wr_busy_rise got=%b want=1", bo); end
      vec_cnt++; if (be !== 1'b0) begin err_cnt++; $display("FAIL wr_busy_fall got=%b want=0", be); end
      vec_cnt++; if (ee !== 1'b0) begin err_cnt++; $display("FAIL wr_err got=%b want=0", ee); end
      vec_cnt++; if (ov !== 1'b0) begin err_cnt++; $display("FAIL wr_o_valid got=%b want=0", ov); end
      do_read(8'h03, nibs, vld, pv, ba, oa);
      vec_cnt++; if (pv !== 1'b0) begin err_cnt++; $display("FAIL rd_early_valid got=%b want=0", pv); end
      vec_cnt++; if (vld !== VLD_ALL) begin err_cnt++; $display("FAIL rd_valid_window got=%b want=%b", vld, VLD_ALL); end
      vec_cnt++; if (nibs[31:0] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rd_data got=%h want=deadbeef", nibs[31:0]); end
`ifdef RV523_NIBBLE_CHK_EN
      vec_cnt++; if (nibs[35:32] !== 4'h0) begin err_cnt++; $display("FAIL rd_chk_nibble got=%h want=0", nibs[35:32]); end
`endif
      vec_cnt++; if (ba !== 1'b0) begin err_cnt++; $display("FAIL rd_busy_fall got=%b want=0", ba); end
      vec_cnt++; if (oa !== 1'b0) begin err_cnt++; $display("FAIL rd_valid_fall got=%b want=0", oa); end
   endtask

   task automatic test_wrap();
      logic pv, ba, oa;
      logic [35:0] nibs;
      logic [8:0]  vld;
      do_read(8'h13, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL wrap_data got=%h want=deadbeef", nibs[31:0]); end
      vec_cnt++; if (vld !== VLD_ALL) begin err_cnt++; $display("FAIL wrap_valid got=%b want=%b", vld, VLD_ALL); end
      do_read(8'h05, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'h00000000) begin err_cnt++; $display("FAIL unwritten_data got=%h want=00000000", nibs[31:0]); end
      vec_cnt++; if (vld !== VLD_ALL) begin err_cnt++; $display("FAIL unwritten_valid got=%b want=%b", vld, VLD_ALL); end
   endtask

   task automatic test_abort();
      logic bo, ee, be, ov, pv, ba, oa;
      logic [35:0] nibs;
      logic [8:0]  vld;
      do_write(4'h8, 8'h03, 32'h12345678, 4, 4'h0, bo, ee, be, ov);
      vec_cnt++; if (ee !== 1'b1) begin err_cnt++; $display("FAIL abort_err got=%b want=1", ee); end
      vec_cnt++; if (be !== 1'b0) begin err_cnt++; $display("FAIL abort_busy got=%b want=0", be); end
      step(1'b0, 4'h0);
      vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL abort_err_pulse got=%b want=0", err); end
      do_read(8'h03, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL abort_old_data got=%h want=deadbeef", nibs[31:0]); end
   endtask

   task automatic test_reserved();
      logic bo, ee, be, ov, pv, ba, oa;
      logic [35:0] nibs;
      logic [8:0]  vld;
      do_write(4'h9, 8'h03, 32'hCAFEF00D, 8, 4'h0, bo, ee, be, ov);
      vec_cnt++; if (ee !== 1'b1) begin err_cnt++; $display("FAIL rsvd_wr_err got=%b want=1", ee); end
      vec_cnt++; if (be !== 1'b0) begin err_cnt++; $display("FAIL rsvd_wr_busy got=%b want=0", be); end
      vec_cnt++; if (ov !== 1'b0) begin err_cnt++; $display("FAIL rsvd_wr_o_valid got=%b want=0", ov); end
      step(1'b0, 4'h0);
      vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL rsvd_err_pulse got=%b want=0", err); end
      do_read(8'h03, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rsvd_no_commit got=%h want=deadbeef", nibs[31:0]); end
      step(1'b1, 4'h1);
      step(1'b1, 4'h0);
`ifdef RV523_NIBBLE_CHK_EN
      step(1'b1, 4'h3);
      step(1'b1, 4'h2);
`else
      step(1'b1, 4'h3);
`endif
      $display("read  op=1 addr=03 (reserved)");
      vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL rsvd_rd_err got=%b want=1", err); end
      vec_cnt++; if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL rsvd_rd_o_valid got=%b want=0", o_valid); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rsvd_rd_busy got=%b want=0", busy); end
      step(1'b0, 4'h0);
      vec_cnt++; if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL rsvd_rd_o_valid_late got=%b want=0", o_valid); end
   endtask

   task automatic test_back_to_back();
      logic bo, ee, be, ov, pv, ba, oa;
      logic [35:0] nibs;
      logic [8:0]  vld;
      do_write(4'h8, 8'h07, 32'h01234567, 8, 4'h0, bo, ee, be, ov);
      do_write(4'h8, 8'h08, 32'h000000F1, 8, 4'h0, bo, ee, be, ov);
      vec_cnt++; if (bo !== 1'b1) begin err_cnt++; $display("FAIL b2b_busy_rise got=%b want=1", bo); end
      do_read(8'h07, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'h01234567) begin err_cnt++; $display("FAIL b2b_word7 got=%h want=01234567", nibs[31:0]); end
      do_read(8'h08, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'h000000F1) begin err_cnt++; $display("FAIL b2b_word8 got=%h want=000000f1", nibs[31:0]); end
`ifdef RV523_NIBBLE_CHK_EN
      vec_cnt++; if (nibs[35:32] !== 4'hE) begin err_cnt++; $display("FAIL b2b_chk_nibble got=%h want=e", nibs[35:32]); end
`endif
   endtask

`ifdef RV523_NIBBLE_CHK_EN
   task automatic test_checksum();
      logic bo, ee, be, ov, pv, ba, oa;
      logic [35:0] nibs;
      logic [8:0]  vld;
      do_write(4'h8, 8'h02, 32'hA5A50F0F, 8, 4'h0, bo, ee, be, ov);
      vec_cnt++; if (ee !== 1'b0) begin err_cnt++; $display("FAIL chk_good_err got=%b want=0", ee); end
      do_read(8'h02, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'hA5A50F0F) begin err_cnt++; $display("FAIL chk_good_data got=%h want=a5a50f0f", nibs[31:0]); end
      do_write(4'h8, 8'h02, 32'h11111111, 8, 4'h1, bo, ee, be, ov);
      vec_cnt++; if (ee !== 1'b1) begin err_cnt++; $display("FAIL chk_bad_err got=%b want=1", ee); end
      vec_cnt++; if (be !== 1'b0) begin err_cnt++; $display("FAIL chk_bad_busy got=%b want=0", be); end
      do_read(8'h02, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'hA5A50F0F) begin err_cnt++; $display("FAIL chk_bad_no_commit got=%h want=a5a50f0f", nibs[31:0]); end
   endtask
`endif

   task automatic test_reset_mid();
      logic pv, ba, oa;
      logic [35:0] nibs;
      logic [8:0]  vld;
      step(1'b1, 4'h0);
      step(1'b1, 4'h0);
      step(1'b1, 4'h3);
`ifdef RV523_NIBBLE_CHK_EN
      step(1'b1, 4'h3);
`endif
      step(1'b0, 4'h0);
      step(1'b0, 4'h0);
      step(1'b0, 4'h0);
      $display("read  addr=03 interrupted by reset at nibble 4");
      vec_cnt++; if (o_d !== 4'hB) begin err_cnt++; $display("FAIL mid_nibble4 got=%h want=b", o_d); end
      #2 rst = 1'b1;
      #1;
      vec_cnt++; if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_o_valid got=%b want=0", o_valid); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
      vec_cnt++; if (o_d !== 4'h0) begin err_cnt++; $display("FAIL mid_rst_o_d got=%h want=0", o_d); end
      @(posedge clk);
      #1 rst = 1'b0;
      do_read(8'h03, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'h00000000) begin err_cnt++; $display("FAIL mid_rst_word3 got=%h want=00000000", nibs[31:0]); end
      do_read(8'h07, nibs, vld, pv, ba, oa);
      vec_cnt++; if (nibs[31:0] !== 32'h00000000) begin err_cnt++; $display("FAIL mid_rst_word7 got=%h want=00000000", nibs[31:0]); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_abort();
      test_reserved();
      test_back_to_back();
`ifdef RV523_NIBBLE_CHK_EN
      test_checksum();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/rv523_nibble_responder.md
# rv523_nibble_responder

Memory-side responder for the RV523 nibble-serial bus: it accepts 4-bit-per-cycle read/write request frames from the core's bus initiator and either commits write data into an internal 32-bit word store or streams read data back nibble-serially. It sits at the far end of the core's load/store path and serves as the scratch/boot memory and the reference endpoint for bus bring-up.

## Interface
- DEPTH, 16: number of 32-bit words; power of two, 2..256
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- I_VALID  in  1  initiator nibble valid
- I_D  in  4  initiator nibble
- O_VALID  out  1  response nibble valid
- O_D  out  4  response nibble
- BUSY  out  1  frame or response in progress
- ERR  out  1  one-cycle error pulse

## Operation
- Request frame, one nibble per cycle with I_VALID=1, no gaps: OP, ADDR_HI, ADDR_LO, then for writes DATA0..DATA7 (DATA0 = bits 3:0, least significant first).
- OP bit 3: 1 = write, 0 = read; OP bits 2:0 reserved, must be 0.
- Word index = ADDR[7:0] mod DEPTH (upper address bits ignored, no error).
- States: IDLE, ADDR, WDATA, CHK, RDATA.
- IDLE: I_VALID=1 captures OP -> ADDR. ADDR: two nibbles -> WDATA (write) or CHK/RDATA (read). WDATA: eight nibbles -> CHK or IDLE. RDATA: eight nibbles out -> CHK-out or IDLE.
- Write commits on the edge that accepts the final frame nibble; a read frame starting the next cycle returns the new value.
- Reserved OP bits nonzero: frame consumed to full length, no write, no read data (O_VALID stays 0), ERR pulses one cycle after final nibble.
- I_VALID low mid-frame: frame aborted, no write, state -> IDLE, ERR pulses next cycle.
- I_VALID during RDATA: ignored; initiator must wait for BUSY=0.
- Memory contents cleared to 0 by RST.

## Timing
- Reset values: O_VALID=0, O_D=0, BUSY=0, ERR=0, state IDLE, all words 0.
- All outputs registered.
- BUSY rises the cycle after OP is accepted; falls the cycle after the last write nibble, or the cycle after the last response nibble.
- Read latency: O_VALID high starting the cycle after the last request nibble is accepted, for exactly 8 consecutive cycles (9 with checksum); O_D = DATA0..DATA7.
- Write frame: 11 cycles (12 with checksum); read round trip: 3+8 cycles (4+9 with checksum).
- Back-to-back: a new OP may be presented the cycle BUSY is 0.
- RST asserted mid-frame or mid-response: immediate return to reset values; partial write never committed.

## Configuration
- RV523_NIBBLE_CHK_EN defined: every request frame carries one extra trailing nibble = XOR of all preceding frame nibbles; mismatch -> write discarded / read not answered, ERR pulses. Read responses append one checksum nibble = XOR of DATA0..DATA7. CHK state present.
- Undefined: no checksum nibble either direction, CHK state absent, ERR driven only by abort and reserved-OP cases.

## Structure
- Shared package rv523_bus_pkg: state enum, OP_WRITE bit index, frame-length constants (ADDR_NIBBLES=2, DATA_NIBBLES=8), nibble XOR function.
- One sub-module: rv523_nibble_shifter (32-bit nibble shift register, load-parallel / shift-in / shift-out), instantiated once and shared between write assembly and read serialisation.

## Test plan
- Write 0x8,0x0,0x3, data 0xDEADBEEF nibbles F,E,E,B,D,A,E,D; then read 0x0,0x0,0x3 -> O_VALID 8 cycles, O_D = F,E,E,B,D,A,E,D, first nibble one cycle after ADDR_LO.
- Read address 0x13 with DEPTH=16 -> returns word 3 contents (wrap); read of unwritten word 5 -> eight 0 nibbles.
- Write frame with I_VALID dropped after DATA3 -> ERR one pulse, BUSY 0, subsequent read of that word returns old value.
- OP=0x9 (reserved bit set) full write frame -> no commit, ERR pulse, O_VALID never asserted.
- RST pulsed during RDATA nibble 4 -> O_VALID/BUSY 0 immediately, all words read back as 0.
- With RV523_NIBBLE_CHK_EN: write frame with correct XOR nibble commits; same frame with checksum off by one -> no commit, ERR; read response ends with ninth nibble = XOR of data nibbles (0xDEADBEEF -> 0x0).
